// File: rtl/rf_port_sched_if.sv
// rtl/rf_port_sched_if.sv - requester-side operand read and writeback bundle of the RF port scheduler
interface rf_port_sched_if #(
    parameter int LANES = 8,
    parameter int DATA  = 32,
    parameter int ADDR  = 3
);
    logic                    rd_req_valid;
    logic [ADDR-1:0]         rd_req_addr;
    logic                    rd_req_ready;
    logic                    rd_rsp_valid;
    logic [ADDR-1:0]         rd_rsp_addr;
    logic [LANES*DATA-1:0]   rd_rsp_data;
    logic                    wb_valid;
    logic [ADDR-1:0]         wb_addr;
    logic [LANES-1:0]        wb_mask;
    logic [LANES*DATA-1:0]   wb_data;
    logic                    wb_ready;

    // Requester side: issues reads and writebacks, consumes responses.
    modport master (
        output rd_req_valid, rd_req_addr, wb_valid, wb_addr, wb_mask, wb_data,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_addr, rd_rsp_data, wb_ready
    );

    // Scheduler side.
    modport slave (
        input  rd_req_valid, rd_req_addr, wb_valid, wb_addr, wb_mask, wb_data,
        output rd_req_ready, rd_rsp_valid, rd_rsp_addr, rd_rsp_data, wb_ready
    );
endinterface

// File: rtl/rf_port_sched.sv
// rtl/rf_port_sched.sv - single-port RF scheduler: read/writeback arbitration, RAW stall, starvation bound
module rf_port_sched #(
    parameter int LANES      = 8,
    parameter int DATA       = 32,
    parameter int ADDR       = 3,
    parameter int WB_DEPTH   = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    rf_port_sched_if.slave          bus,
    output logic [LANES-1:0]        RF_WR_MASK,
    output logic [ADDR-1:0]         RF_Addr,
    output logic                    RF_WR,
    output logic [LANES*DATA-1:0]   WriteData,
    input  logic [LANES*DATA-1:0]   DataOut
);
    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_READ  = 2'd1,
        SLOT_WRITE = 2'd2
    } slot_t;

    logic [ADDR-1:0]        r_fifo_addr [WB_DEPTH];
    logic [LANES-1:0]       r_fifo_mask [WB_DEPTH];
    logic [LANES*DATA-1:0]  r_fifo_data [WB_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [STV_W-1:0]       r_starve;
    logic                   r_rd_v1;
    logic [ADDR-1:0]        r_rd_a1;
    logic                   r_rd_v2;
    logic [ADDR-1:0]        r_rd_a2;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_hazard;
    logic [WB_DEPTH-1:0]    w_live_hit;
    logic                   w_push;
    logic                   w_pop;
    slot_t                  w_slot;

    assign w_full  = (r_count == CNT_W'(WB_DEPTH));
    assign w_empty = (r_count == '0);

    // An entry can stall a read only while it sits in the FIFO (registered state, so a
    // same-cycle push is invisible) and only if it actually writes some lane.
    for (genvar g = 0; g < WB_DEPTH; g++) begin : g_hazard
        logic [PTR_W-1:0] w_ofs;
        assign w_ofs = PTR_W'(g) - r_rd_ptr;
        assign w_live_hit[g] = ({1'b0, w_ofs} < r_count)
                             && (r_fifo_mask[g] != '0)
                             && (r_fifo_addr[g] == bus.rd_req_addr);
    end
    assign w_hazard = bus.rd_req_valid && (|w_live_hit);

    // Slot arbiter: full, starvation and hazard force a write ahead of any read.
    always_comb begin
        w_slot = SLOT_IDLE;
        if (w_full) begin
            w_slot = SLOT_WRITE;
        end else if (!w_empty && (r_starve == STV_W'(STARVE_LIM))) begin
            w_slot = SLOT_WRITE;
        end else if (w_hazard) begin
            w_slot = SLOT_WRITE;
        end else if (bus.rd_req_valid) begin
            w_slot = SLOT_READ;
        end else if (!w_empty) begin
            w_slot = SLOT_WRITE;
        end
    end

    assign w_push = bus.wb_valid && !w_full;
    assign w_pop  = (w_slot == SLOT_WRITE);

    assign bus.wb_ready     = !w_full;
    assign bus.rd_req_ready = (w_slot == SLOT_READ);
    assign bus.rd_rsp_valid = r_rd_v2;
    assign bus.rd_rsp_addr  = r_rd_a2;
    assign bus.rd_rsp_data  = DataOut;

    // FIFO payload storage; liveness is tracked by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.wb_addr;
            r_fifo_mask[r_wr_ptr] <= bus.wb_mask;
            r_fifo_data[r_wr_ptr] <= bus.wb_data;
        end
    end

    // FIFO bookkeeping, starvation counter, issue register and read-return pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            RF_WR      <= 1'b0;
            RF_WR_MASK <= '0;
            RF_Addr    <= '0;
            WriteData  <= '0;
            r_rd_v1    <= 1'b0;
            r_rd_a1    <= '0;
            r_rd_v2    <= 1'b0;
            r_rd_a2    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (r_starve != STV_W'(STARVE_LIM)) begin
                r_starve <= r_starve + STV_W'(1);
            end

            // The BRAM writes on mask alone, so the mask is cleared on every non-write slot.
            case (w_slot)
                SLOT_WRITE: begin
                    RF_WR      <= 1'b1;
                    RF_WR_MASK <= r_fifo_mask[r_rd_ptr];
                    RF_Addr    <= r_fifo_addr[r_rd_ptr];
                    WriteData  <= r_fifo_data[r_rd_ptr];
                end
                SLOT_READ: begin
                    RF_WR      <= 1'b0;
                    RF_WR_MASK <= '0;
                    RF_Addr    <= bus.rd_req_addr;
                    WriteData  <= '0;
                end
                default: begin
                    RF_WR      <= 1'b0;
                    RF_WR_MASK <= '0;
                    RF_Addr    <= '0;
                    WriteData  <= '0;
                end
            endcase

            r_rd_v1 <= (w_slot == SLOT_READ);
            r_rd_a1 <= bus.rd_req_addr;
            r_rd_v2 <= r_rd_v1;
            r_rd_a2 <= r_rd_a1;
        end
    end
endmodule

// File: doc/rf_port_sched.md
# rf_port_sched

Single-port scheduler for the masked 8-lane vector register-file BRAM. It sits directly upstream of the masked RF and time-multiplexes its one shared address port between operand reads and buffered writebacks. It drives RF_WR_MASK, RF_Addr, RF_WR and WriteData, and returns DataOut to the read requester with a valid flag. It also resolves read-after-write hazards against pending writebacks and bounds writeback starvation.

## Interface
- LANES, 8, number of 32-bit lanes
- DATA, 32, bits per lane
- ADDR, 3, RF address width
- WB_DEPTH, 4, writeback FIFO entries (power of two)
- STARVE_LIM, 4, cycles a non-empty FIFO may wait before forced drain

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- rd_req_valid  in  1  operand read request
- rd_req_addr  in  ADDR  read address
- rd_req_ready  out  1  read accepted when valid&&ready at edge
- rd_rsp_valid  out  1  rd_rsp_data valid this cycle
- rd_rsp_addr  out  ADDR  address of returned read
- rd_rsp_data  out  LANES*DATA  equals DataOut
- wb_valid  in  1  writeback request
- wb_addr  in  ADDR  writeback address
- wb_mask  in  LANES  per-lane write enable
- wb_data  in  LANES*DATA  writeback data
- wb_ready  out  1  FIFO has space
- RF_WR_MASK  out  LANES  per-lane BRAM write enable
- RF_Addr  out  ADDR  BRAM address
- RF_WR  out  1  write slot indicator
- WriteData  out  LANES*DATA  BRAM write data
- DataOut  in  LANES*DATA  BRAM registered read data

## Operation
- Writeback FIFO: WB_DEPTH entries of {addr, mask, data}. wb_ready = (count < WB_DEPTH), registered-count based; no same-cycle push-when-full even if popping.
- Per cycle, the arbiter chooses one slot: WRITE (pop FIFO head), READ (accept rd_req), or IDLE. Priority:
  1. FIFO full -> WRITE.
  2. starve_cnt == STARVE_LIM -> WRITE.
  3. rd_req_valid and rd_req_addr matches addr of any valid FIFO entry with nonzero mask -> WRITE (hazard; read stalls).
  4. rd_req_valid -> READ.
  5. FIFO non-empty -> WRITE.
  6. else IDLE.
- rd_req_ready = 1 only when the slot is READ (combinational from FIFO state, starve_cnt, rd_req_*).
- An entry with mask == 0 is popped normally: RF_WR=1, RF_WR_MASK=0, no lanes change, and it never triggers hazard stalls.
- starve_cnt: resets to 0 on any WRITE slot or when the FIFO is empty; otherwise increments on each READ/IDLE slot, saturating at STARVE_LIM.
- An entry pushed in cycle t is not hazard-visible until t+1; a read accepted in t with the same address reads old data (read-before-write ordering).
- Issue register: the RF_* outputs are registered from the slot decision.
  - WRITE: RF_WR=1, RF_Addr=entry.addr, RF_WR_MASK=entry.mask, WriteData=entry.data.
  - READ: RF_WR=0, RF_WR_MASK=0, RF_Addr=rd_req_addr, WriteData=0.
  - IDLE: all zero.
- The BRAM ignores RF_WR and writes on the mask alone, so RF_WR_MASK must be 0 on every non-write cycle.
- Read-return pipeline: 2-stage valid/address shift. rd_rsp_data = DataOut passthrough, meaningful only when rd_rsp_valid=1.

## Timing
- Reset (rst=0, async): FIFO empty, starve_cnt=0, and RF_WR_MASK, RF_Addr, RF_WR, WriteData, rd_rsp_valid, rd_rsp_addr all 0. wb_ready=1 and rd_req_ready follows rule 4 once released. In-flight reads are dropped with no response.
- Read latency: accepted at edge E0 -> RF_Addr valid after E0 -> BRAM samples at E1 -> rd_rsp_valid=1 in the cycle after E1 (2 cycles after acceptance). Fully pipelined: one read per cycle.
- Writeback latency: pushed at E0 -> earliest RF_* write issue after E1 -> array updated at E2.
- A read accepted at E(n) returns data including every write whose slot was decided before E(n). Guaranteed by the hazard rule plus the 1-cycle issue register.
- Simultaneous push and pop: both occur, and count is unchanged.
- Forced drain under continuous reads: at most STARVE_LIM consecutive READ slots while the FIFO is non-empty.

## Test plan
- Reset mid-operation: assert rst with 3 FIFO entries and 2 reads in flight -> all outputs 0 immediately, wb_ready=1, and no rd_rsp_valid afterwards.
- Read latency: idle, read addr 5 holding 0xA5A5A5A5 in all lanes -> rd_rsp_valid exactly 2 cycles after acceptance, rd_rsp_addr=5, data matches. Back-to-back reads of 0..7 -> 8 consecutive responses in order.
- Masked writeback: wb addr 2, mask 8'b1000_0001, data lanes = lane index + 0x100 -> after drain, read of addr 2 shows only lanes 0 and 7 changed, other lanes keep old values, and RF_WR_MASK=0 on every non-write cycle.
- RAW hazard: push wb addr 3, then next cycle read addr 3 -> rd_req_ready=0 until that entry issues, and the read returns the new data.
- Starvation: continuous reads to addr 1 with 1 pending write to addr 6 (STARVE_LIM=4) -> 4 READ slots, then 1 forced WRITE, then reads resume.
- Full FIFO: push 4 writebacks with rd_req_valid held high -> wb_ready=0 at count 4, WRITE slots win, and all 4 entries retire in FIFO order.
